// File: rtl/key_debounce_bank.sv
// key_debounce_bank: per-channel two-flop synchroniser, stable-sample debouncer
// and press / release / long-press / auto-repeat pulse generator for panel keys.
module key_debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 10_000_000,
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 12_500_000,
  parameter int ACTIVE_LOW    = 1,
  parameter int CNT_W         = 27
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key_in,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_press,
  output logic [CHANNELS-1:0] key_release,
  output logic [CHANNELS-1:0] key_long,
  output logic [CHANNELS-1:0] key_repeat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } holdState_t;

  // Pin level of a released key; synchronisers reset here so reset exit is edge-free.
  localparam logic             PIN_IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  for (genvar g = 0; g < CHANNELS; g++) begin : gChan
    logic             sync1R, sync2R, rawS;
    logic [CNT_W-1:0] debCntR, debCntS;
    logic             levelR, levelS, acceptS, riseS, fallS;
    holdState_t       stateR, stateS;
    logic [CNT_W-1:0] holdCntR, holdCntS;
    logic             pressR, relR, longR, rptR;
    logic             pressS, relS, longS, rptS;

    assign rawS = sync2R ^ PIN_IDLE;

    // Debounce: count consecutive samples that disagree with the accepted level.
    always_comb begin
      debCntS = '0;
      acceptS = 1'b0;
      if (rawS != levelR) begin
        if (debCntR >= STABLE_LAST) begin
          acceptS = 1'b1;
          debCntS = '0;
        end else begin
          debCntS = debCntR + CNT_ONE;
        end
      end else begin
        debCntS = '0;
      end
    end

    assign levelS = acceptS ? rawS : levelR;
    assign riseS  = acceptS & rawS;
    assign fallS  = acceptS & ~rawS;

    // Hold FSM: a falling level is checked first so release masks long/repeat.
    always_comb begin
      stateS   = stateR;
      holdCntS = '0;
      pressS   = 1'b0;
      relS     = 1'b0;
      longS    = 1'b0;
      rptS     = 1'b0;
      case (stateR)
        IDLE: begin
          if (riseS) begin
            pressS = 1'b1;
            stateS = HELD;
          end else begin
            stateS = IDLE;
          end
        end
        HELD: begin
          if (fallS) begin
            relS   = 1'b1;
            stateS = IDLE;
          end else if (holdCntR >= LONG_LAST) begin
            longS  = 1'b1;
            stateS = LONG;
          end else begin
            holdCntS = holdCntR + CNT_ONE;
          end
        end
        LONG: begin
          if (fallS) begin
            relS   = 1'b1;
            stateS = IDLE;
          end else if (holdCntR >= REPEAT_LAST) begin
            rptS = 1'b1;
          end else begin
            holdCntS = holdCntR + CNT_ONE;
          end
        end
        default: begin
          stateS = IDLE;
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1R   <= PIN_IDLE;
        sync2R   <= PIN_IDLE;
        debCntR  <= '0;
        levelR   <= 1'b0;
        stateR   <= IDLE;
        holdCntR <= '0;
        pressR   <= 1'b0;
        relR     <= 1'b0;
        longR    <= 1'b0;
        rptR     <= 1'b0;
      end else begin
        sync1R   <= key_in[g];
        sync2R   <= sync1R;
        debCntR  <= debCntS;
        levelR   <= levelS;
        stateR   <= stateS;
        holdCntR <= holdCntS;
        pressR   <= pressS;
        relR     <= relS;
        longR    <= longS;
        rptR     <= rptS;
      end
    end

    assign key_level[g]   = levelR;
    assign key_press[g]   = pressR;
    assign key_release[g] = relR;
    assign key_long[g]    = longR;
    assign key_repeat[g]  = rptR;
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank: expected pulses are queued with their
// due cycle when a pin is driven, then every cycle's outputs are compared.
module tb_key_debounce_bank;

  localparam int K_PRESS  = 0;
  localparam int K_REL    = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] key_in = 2'b11;
  logic [1:0] key_level, key_press, key_release, key_long, key_repeat;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t        evQ[$];
  int         cyc = 0;
  int         testCnt = 0;
  int         failCnt = 0;
  logic [1:0] expLevel = 2'b00;

  key_debounce_bank #(
    .CHANNELS(2), .STABLE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
    .ACTIVE_LOW(1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_long(key_long),
    .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  task automatic pushEv(input int at, input int ch, input int kind);
    ev_t e;
    e.cyc  = at;
    e.ch   = ch;
    e.kind = kind;
    evQ.push_back(e);
  endtask

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] want);
    testCnt++;
    assert (got === want) else begin
      failCnt++;
      $error("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, got, want);
    end
  endtask

  task automatic setKey(input int ch, input bit pressed);
    key_in[ch] = pressed ? 1'b0 : 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_level"},   key_level,   2'b00);
    check({tag, "_press"},   key_press,   2'b00);
    check({tag, "_release"}, key_release, 2'b00);
    check({tag, "_long"},    key_long,    2'b00);
    check({tag, "_repeat"},  key_repeat,  2'b00);
  endtask

  // Advance n cycles; after each edge pop due events and compare every output.
  task automatic tick(input int n);
    logic [1:0] eP, eR, eL, eRp;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      eP = 2'b00; eR = 2'b00; eL = 2'b00; eRp = 2'b00;
      for (int i = evQ.size() - 1; i >= 0; i--) begin
        if (evQ[i].cyc == cyc) begin
          case (evQ[i].kind)
            K_PRESS:  eP[evQ[i].ch]  = 1'b1;
            K_REL:    eR[evQ[i].ch]  = 1'b1;
            K_LONG:   eL[evQ[i].ch]  = 1'b1;
            default:  eRp[evQ[i].ch] = 1'b1;
          endcase
          evQ.delete(i);
        end
      end
      expLevel = (expLevel | eP) & ~eR;
      check("level",   key_level,   expLevel);
      check("press",   key_press,   eP);
      check("release", key_release, eR);
      check("long",    key_long,    eL);
      check("repeat",  key_repeat,  eRp);
    end
  endtask

  initial begin
    int c, p, d;
    // Reset state
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Clean press on channel 0, held 10 cycles: level/press after E5
    c = cyc;
    setKey(0, 1'b1);
    pushEv(c + 6, 0, K_PRESS);
    tick(10);
    setKey(0, 1'b0);
    pushEv(c + 16, 0, K_REL);
    tick(14);

    // Bounce: 3 low / 1 high, five times, never reaches 4 stable samples
    for (int r = 0; r < 5; r++) begin
      setKey(0, 1'b1);
      tick(3);
      setKey(0, 1'b0);
      tick(1);
    end
    tick(12);

    // Long press and auto-repeat, then release from LONG
    c = cyc;
    p = c + 6;
    setKey(0, 1'b1);
    pushEv(p, 0, K_PRESS);
    pushEv(p + 20, 0, K_LONG);
    for (int k = 1; k <= 5; k++) pushEv(p + 20 + 8 * k, 0, K_REPEAT);
    pushEv(p + 66, 0, K_REL);
    tick(p + 60 - cyc);
    setKey(0, 1'b0);
    tick(24);

    // Release lands on the edge where key_long would fire
    c = cyc;
    p = c + 6;
    setKey(0, 1'b1);
    pushEv(p, 0, K_PRESS);
    pushEv(p + 20, 0, K_REL);
    tick(p + 14 - cyc);
    setKey(0, 1'b0);
    tick(30);

    // Two channels pressed 2 cycles apart, then reset mid-hold
    c = cyc;
    setKey(0, 1'b1);
    pushEv(c + 6, 0, K_PRESS);
    tick(2);
    setKey(1, 1'b1);
    pushEv(c + 8, 1, K_PRESS);
    tick(10);
    rst = 1'b1;
    #1;
    expLevel = 2'b00;
    checkAllZero("rst_async");
    tick(2);
    rst = 1'b0;
    d = cyc;
    pushEv(d + 6, 0, K_PRESS);
    pushEv(d + 6, 1, K_PRESS);
    tick(8);
    setKey(0, 1'b0);
    setKey(1, 1'b0);
    pushEv(d + 14, 0, K_REL);
    pushEv(d + 14, 1, K_REL);
    tick(12);

    testCnt++;
    assert (evQ.size() == 0) else begin
      failCnt++;
      $error("FAIL pending_events got=%0d want=0", evQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
